current_mirror_array: RTL and testbench



---
 rtl/current_mirror_pkg.sv | 20 ++
 rtl/current_mirror_ramp_fsm.sv | 118 +++++++++++
 rtl/current_mirror_array.sv | 78 +++++++
 tb/tb_current_mirror_array.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/current_mirror_pkg.sv
// current_mirror_pkg
//   Shared types and helpers for the multi-channel current mirror.
//   - state_t     : ramp controller states
//   - ch_w()      : channel-index width, never below 1 bit
//   - mirror_gain : signed real gain for a given code
package current_mirror_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE, DONE} state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // sink = 1 means the NMOS side drives the output, so current flows in.
  function automatic real mirror_gain(input int code, input real g0,
                                      input real gstep, input int sink);
    return ((sink != 0) ? -1.0 : 1.0) * (g0 + gstep * real'(code));
  endfunction

endpackage

// File: rtl/current_mirror_ramp_fsm.sv
// current_mirror_ramp_fsm
//   Digital side of the mirror array: request handshake, code ramp FSM,
//   step/settle counter and the per-channel code register file.
//   Ports:
//     clk, rstb            clock, async active-low reset
//     cfg_valid/cfg_ready  request handshake (accept on valid && ready)
//     cfg_ch, cfg_code     target channel / target code
//     busy                 request in progress (RAMP, SETTLE, DONE)
//     done                 one-cycle completion pulse
//     err                  one-cycle pulse for an out-of-range channel
//     code_mon             registered codes, channel 0 in the LSBs
module current_mirror_ramp_fsm
  import current_mirror_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CODE_W     = 2,
  parameter int DEF_CODE   = 1,
  parameter int STEP_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_w(NCH)-1:0]     cfg_ch,
  input  logic [CODE_W-1:0]        cfg_code,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NCH*CODE_W-1:0]    code_mon
);

  localparam int CHW     = ch_w(NCH);
  localparam int CNT_MAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic [CHW-1:0]    ch;
    logic [CODE_W-1:0] code;
  } req_t;

  state_t                     state_q, state_d;
  req_t                       req_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NCH-1:0][CODE_W-1:0] code_q;
  logic                       err_q;

  logic [2**CHW-1:0]          ch_ok;
  logic                       accept, ch_good;
  logic [CODE_W-1:0]          cur, nxt;
  logic                       cur_at_tgt, step_now, last_step, settle_end;

  // Lookup of legal channel numbers; avoids a range compare that can be
  // constant when NCH is a power of two.
  always_comb begin
    ch_ok = '0;
    for (int j = 0; j < 2**CHW; j++) ch_ok[j] = (j < NCH);
  end

  assign accept     = cfg_valid && (state_q == IDLE);
  assign ch_good    = ch_ok[cfg_ch];
  assign cur        = code_q[req_q.ch];
  assign cur_at_tgt = (cur == req_q.code);
  assign step_now   = (cnt_q == CNT_W'(STEP_CYC - 1));
  // One LSB toward the target; stepping stops on equality, so no overshoot
  // and no wrap.
  assign nxt        = (req_q.code > cur) ? cur + CODE_W'(1) : cur - CODE_W'(1);
  assign last_step  = step_now && (nxt == req_q.code);
  assign settle_end = (cnt_q == CNT_W'(SETTLE_CYC - 1));

  // State register, counter, request latch and code file
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) code_q[i] <= CODE_W'(DEF_CODE);
    end else begin
      state_q <= state_d;
      err_q   <= accept && !ch_good;
      if (accept && ch_good) req_q <= '{ch: cfg_ch, code: cfg_code};
      if (state_q == RAMP && !cur_at_tgt && step_now) code_q[req_q.ch] <= nxt;
      if (state_d != state_q || (state_q == RAMP && step_now))
        cnt_q <= '0;
      else if (state_q == RAMP || state_q == SETTLE)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state. A request always passes through RAMP so the target is
  // compared against the latched copy; a same-code request leaves RAMP on
  // its first cycle, which puts done one cycle later than the accept edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept && ch_good) state_d = RAMP;
      RAMP: begin
        if (cur_at_tgt)     state_d = DONE;
        else if (last_step) state_d = (SETTLE_CYC == 0) ? DONE : SETTLE;
      end
      SETTLE: if (settle_end) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = err_q;
  end

  assign code_mon = code_q;

endmodule

// File: rtl/current_mirror_array.sv
// current_mirror_array
//   NCH-channel current mirror. Each channel scales iref by a gain set by
//   its code; code changes are ramped one LSB at a time by the ramp FSM.
//   Ports:
//     clk, rstb            clock, async active-low reset
//     vdd, vss             supply rails (no functional effect)
//     iref                 reference current (real)
//     cfg_valid/cfg_ready  code-change handshake
//     cfg_ch, cfg_code     target channel / code
//     ch_en                per-channel output enable, combinational
//     busy, done, err      request status
//     code_mon             current code per channel, channel 0 in LSBs
//     out                  mirrored currents (real, one per channel)
module current_mirror_array
  import current_mirror_pkg::*;
#(
  parameter int  NCH        = 2,
  parameter int  CODE_W     = 2,
  parameter int  DEF_CODE   = 1,
  parameter int  STEP_CYC   = 4,
  parameter int  SETTLE_CYC = 8,
  parameter real G0         = 0.984,
  parameter real GSTEP      = -0.244,
  parameter int  SINK       = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  real                   vdd,
  input  real                   vss,
  input  real                   iref,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [CODE_W-1:0]     cfg_code,
  input  logic [NCH-1:0]        ch_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NCH*CODE_W-1:0] code_mon,
  output real                   out [NCH]
);

  real supply_tie;

  current_mirror_ramp_fsm #(
    .NCH        (NCH),
    .CODE_W     (CODE_W),
    .DEF_CODE   (DEF_CODE),
    .STEP_CYC   (STEP_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_fsm (
    .clk       (clk),
    .rstb      (rstb),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_code  (cfg_code),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .code_mon  (code_mon)
  );

  // Rails are carried for netlist compatibility only; zero weight keeps
  // them referenced without affecting the mirrored current.
  assign supply_tie = 0.0 * (vdd - vss);

  // Scaling stages: follow code_mon and ch_en with no clock latency.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      out[i] = ch_en[i]
             ? mirror_gain(int'(code_mon[i*CODE_W +: CODE_W]), G0, GSTEP, SINK) * iref
               + supply_tie
             : 0.0;
    end
  end

endmodule

// File: tb/tb_current_mirror_array.sv
module tb_current_mirror_array;

  localparam int  STEP   = 4;
  localparam int  SETTLE = 8;
  localparam real G0     = 0.984;
  localparam real GSTEP  = -0.244;
  localparam real IREF   = 100.0;   // microamps

  logic clk = 1'b0;
  logic rstb;
  real  vdd = 1.8, vss = 0.0, iref = IREF;

  // DUT a: all defaults (NCH=2, sink)
  logic       a_valid, a_ready, a_busy, a_done, a_err;
  logic       a_ch;
  logic [1:0] a_code, a_en;
  logic [3:0] a_mon;
  real        a_out [2];

  // DUT b: NCH=3 so an out-of-range channel is encodable, source polarity,
  // fastest stepping and no settle interval
  logic       b_valid, b_ready, b_busy, b_done, b_err;
  logic [1:0] b_ch, b_code;
  logic [2:0] b_en;
  logic [5:0] b_mon;
  real        b_out [3];

  int total = 0, bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  current_mirror_array dut_a (
    .clk(clk), .rstb(rstb), .vdd(vdd), .vss(vss), .iref(iref),
    .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_ch(a_ch), .cfg_code(a_code),
    .ch_en(a_en), .busy(a_busy), .done(a_done), .err(a_err),
    .code_mon(a_mon), .out(a_out)
  );

  current_mirror_array #(.NCH(3), .SINK(0), .STEP_CYC(1), .SETTLE_CYC(0)) dut_b (
    .clk(clk), .rstb(rstb), .vdd(vdd), .vss(vss), .iref(iref),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_ch(b_ch), .cfg_code(b_code),
    .ch_en(b_en), .busy(b_busy), .done(b_done), .err(b_err),
    .code_mon(b_mon), .out(b_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    real d;
    total++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > 1e-6) begin
      bad++;
      $display("FAIL %s: got %f want %f (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of DUT a ----------------
  // Works from the timeline rules: a request accepted at edge k moves the
  // code at k+STEP, k+2*STEP ..., done follows edge k+d*STEP+SETTLE (or k+1
  // when d=0), and the block is ready again one edge after that.
  int cyc = 0;
  int m_code [2] = '{1, 1};
  bit m_act = 0, m_done = 0;
  int m_k, m_ch, m_tgt, m_de;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_code = '{1, 1};
      m_act  = 0;
      m_done = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (m_act) begin
        if (cyc > m_k && ((cyc - m_k) % STEP) == 0 && m_code[m_ch] != m_tgt)
          m_code[m_ch] += (m_tgt > m_code[m_ch]) ? 1 : -1;
        if (cyc == m_de) m_done = 1;
        if (cyc == m_de + 1) m_act = 0;
      end else if (a_valid) begin
        int d;
        m_act = 1;
        m_k   = cyc;
        m_ch  = int'(a_ch);
        m_tgt = int'(a_code);
        d     = (m_tgt > m_code[m_ch]) ? m_tgt - m_code[m_ch] : m_code[m_ch] - m_tgt;
        m_de  = (d > 0) ? cyc + d * STEP + SETTLE : cyc + 1;
      end
    end
  end

  // Compare DUT a against the model every cycle, between the edges.
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("a_code_mon", int'(a_mon[i*2 +: 2]), m_code[i]);
        chk_r("a_out", a_out[i],
              a_en[i] ? -1.0 * (G0 + GSTEP * real'(m_code[i])) * IREF : 0.0);
      end
      chk("a_ready", int'(a_ready), int'(!m_act));
      chk("a_busy",  int'(a_busy),  int'(m_act));
      chk("a_done",  int'(a_done),  int'(m_done));
      chk("a_err",   int'(a_err),   0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic a_req(input int ch, input int code, output int acc);
    int n = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_ch    = 1'(ch);
    a_code  = 2'(code);
    while (!a_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL a_req_accept: got no ready within %0d cycles", n);
    end
    acc = cyc + 1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_a_done(output int e);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!a_done && n < 300);
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL a_done_wait: got no done within %0d cycles", n);
    end
    e = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k1, k2, k3, k4, e1, e2, e3, ndone;
    rstb = 1'b0;
    a_valid = 0; a_ch = 0; a_code = 0; a_en = 2'b11;
    b_valid = 0; b_ch = 0; b_code = 0; b_en = 3'b111;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    chk_on = 1;
    #1;
    // reset state, hand values
    chk("rst_a_mon", a_mon, 4'b0101);
    chk_r("rst_a_out0", a_out[0], -74.0);
    chk_r("rst_a_out1", a_out[1], -74.0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_mon", b_mon, 6'b010101);
    chk_r("rst_b_out0", b_out[0], 74.0);

    // ramp ch1 1->3, with a second request held during the ramp
    a_req(1, 3, k1);
    repeat (3) @(posedge clk);
    #2;
    chk("ramp_pre_step", a_mon, 4'b0101);
    @(posedge clk); #2;
    chk("ramp_step1", a_mon, 4'b1001);
    chk_r("ramp_out1_s1", a_out[1], -49.6);
    chk_r("ramp_out0_hold", a_out[0], -74.0);
    repeat (4) @(posedge clk);
    #2;
    chk("ramp_step2", a_mon, 4'b1101);
    chk_r("ramp_out1_s2", a_out[1], -25.2);
    fork
      wait_a_done(e1);
      a_req(0, 0, k2);
    join
    chk("ramp_done_lat", e1 - k1, 16);
    chk("held_accept_lat", k2 - k1, 18);
    wait_a_done(e2);
    chk("down_done_lat", e2 - k2, 12);
    chk("down_codes", a_mon, 4'b1100);

    // same-code request
    a_req(0, 0, k3);
    wait_a_done(e3);
    chk("same_done_lat", e3 - k3, 1);
    chk("same_codes", a_mon, 4'b1100);

    // enable gating is immediate and keeps the code
    @(negedge clk);
    a_en = 2'b10;
    #1;
    chk_r("en_off_out0", a_out[0], 0.0);
    chk_r("en_keep_out1", a_out[1], -25.2);
    chk("en_off_codes", a_mon, 4'b1100);
    repeat (2) @(negedge clk);
    a_en = 2'b11;

    // mid-ramp reset: codes back to default asynchronously, no done later
    a_req(0, 3, k4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("mid_rst_codes", a_mon, 4'b0101);
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_busy", a_busy, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #2;
      if (a_done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    // DUT b: out-of-range channel -> err only
    @(negedge clk);
    b_valid = 1'b1; b_ch = 2'd3; b_code = 2'd0;
    @(posedge clk); #2;
    chk("err_pulse", b_err, 1);
    chk("err_ready", b_ready, 1);
    chk("err_busy", b_busy, 0);
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk); #2;
    chk("err_clear", b_err, 0);
    chk("err_no_done", b_done, 0);
    chk("err_codes", b_mon, 6'b010101);

    // DUT b: source polarity, single step with no settle
    @(negedge clk);
    b_valid = 1'b1; b_ch = 2'd2; b_code = 2'd0;
    @(posedge clk); #2;
    chk("b_acc_busy", b_busy, 1);
    chk("b_acc_ready", b_ready, 0);
    @(negedge clk);
    b_valid = 1'b0;
    @(posedge clk); #2;
    chk("b_done", b_done, 1);
    chk("b_codes", b_mon, 6'b000101);
    chk_r("b_out2_src", b_out[2], 98.4);
    chk_r("b_out0_src", b_out[0], 74.0);
    @(posedge clk); #2;
    chk("b_done_clear", b_done, 0);
    chk("b_ready_back", b_ready, 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
